// File: rtl/ve_array_argmax_stream_pkg.sv
// Shared types and helpers for the streaming argmax/argmin reducer.
// Holds the reduction mode, the beat tag and the strict compare.
package VEArrayPkg;

    localparam int MAXW = 64;

    typedef enum logic {
        RED_MAX = 1'b0,
        RED_MIN = 1'b1
    } red_mode_e;

    typedef struct packed {
        logic      valid;
        logic      last;
        logic      first;
        logic      ovf;
        red_mode_e mode;
    } beat_tag_t;

    function automatic int layer_of(input int eltnum);
        return $clog2(eltnum);
    endfunction

    function automatic int idx_width(input int eltnum, input int maxbeats);
        return $clog2(eltnum * maxbeats);
    endfunction

    function automatic int bc_width(input int maxbeats);
        return $clog2(maxbeats + 1);
    endfunction

    // True when a is strictly better than b (ties never win).
    function automatic logic better(
        input logic [MAXW-1:0] a,
        input logic [MAXW-1:0] b,
        input red_mode_e       mode,
        input logic            sgn
    );
        logic gt;
        logic lt;
        if (sgn) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        return (mode == RED_MIN) ? lt : gt;
    endfunction

endpackage

// File: rtl/ve_array_argmax_stream_cmp_sel.sv
// One compare/select node: picks b only when strictly better than a,
// so on ties the left (lower-index) operand is kept.
module ve_cmp_sel
    import VEArrayPkg::*;
#(
    parameter int W      = 16,
    parameter int IW     = 4,
    parameter int SIGNED = 1
) (
    input  logic [W-1:0]  a_val,
    input  logic [IW-1:0] a_idx,
    input  logic [W-1:0]  b_val,
    input  logic [IW-1:0] b_idx,
    input  red_mode_e     mode,
    output logic [W-1:0]  val,
    output logic [IW-1:0] idx,
    output logic          take_b
);

    logic [MAXW-1:0] a_ext;
    logic [MAXW-1:0] b_ext;

    always_comb begin
        if (SIGNED != 0) begin
            a_ext = MAXW'($signed(a_val));
            b_ext = MAXW'($signed(b_val));
        end else begin
            a_ext = MAXW'(a_val);
            b_ext = MAXW'(b_val);
        end
    end

    assign take_b = better(b_ext, a_ext, mode, SIGNED != 0);
    assign val    = take_b ? b_val : a_val;
    assign idx    = take_b ? b_idx : a_idx;

endmodule

// File: rtl/ve_array_argmax_stream.sv
// Streaming max/min reducer with index tracking over multi-beat rows.
// Heap-ordered compare tree, optional per-layer registers, then accumulator.
module ve_array_argmax_stream
    import VEArrayPkg::*;
#(
    parameter int ELTNUM   = 4,
    parameter int ELTBIT   = 16,
    parameter int SIGNED   = 1,
    parameter int MAXBEATS = 256,
    parameter logic [layer_of(ELTNUM)-1:0] PIPE = '1,
    parameter int IDXW     = idx_width(ELTNUM, MAXBEATS),
    parameter int BCW      = bc_width(MAXBEATS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic                     inLast,
    input  logic                     inMode,
    input  logic [ELTNUM*ELTBIT-1:0] inVec,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [ELTBIT-1:0]        outElt,
    output logic [IDXW-1:0]          outIdx,
    output logic [BCW-1:0]           outBeats,
    output logic                     outOvf
);

    localparam int LAYER = layer_of(ELTNUM);
    localparam int BNW   = IDXW - LAYER;
    localparam int NODES = 2 * ELTNUM;

    if (ELTNUM < 2 || (ELTNUM & (ELTNUM - 1)) != 0) begin : g_bad_eltnum
        $fatal(1, "ELTNUM must be a power of 2 and >= 2");
    end
    if (ELTBIT < 1 || ELTBIT > MAXW) begin : g_bad_eltbit
        $fatal(1, "ELTBIT out of range");
    end
    if (MAXBEATS < 2) begin : g_bad_maxbeats
        $fatal(1, "MAXBEATS must be >= 2");
    end

    logic en;
    logic accept;
    logic [BCW-1:0] cnt;
    logic first_q;
    red_mode_e row_mode;
    logic beat_ovf;

    assign en       = ~outValid | outReady;
    assign inReady  = en;
    assign accept   = inValid & en;
    assign beat_ovf = (cnt == BCW'(MAXBEATS));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            first_q  <= 1'b1;
            row_mode <= RED_MAX;
        end else if (accept) begin
            if (inLast) begin
                cnt     <= '0;
                first_q <= 1'b1;
            end else begin
                first_q <= 1'b0;
                if (!beat_ovf) cnt <= cnt + 1'b1;
            end
            if (first_q) row_mode <= red_mode_e'(inMode);
        end
    end

    beat_tag_t      tag    [LAYER+1];
    logic [BCW-1:0] tbeats [LAYER+1];
    beat_tag_t      tag_in;

    // Later beats reuse the mode latched from the row's first beat.
    always_comb begin
        tag_in       = '0;
        tag_in.valid = inValid;
        tag_in.last  = inValid & inLast;
        tag_in.first = first_q;
        tag_in.ovf   = beat_ovf;
        tag_in.mode  = first_q ? red_mode_e'(inMode) : row_mode;
    end

    assign tag[0]    = tag_in;
    assign tbeats[0] = beat_ovf ? cnt : cnt + 1'b1;

    for (genvar i = 0; i < LAYER; i++) begin : g_tag
        if (PIPE[i]) begin : g_reg
            beat_tag_t      tq;
            logic [BCW-1:0] bq;
            always_ff @(posedge clk) begin
                if (rst) begin
                    tq <= '0;
                    bq <= '0;
                end else if (en) begin
                    tq <= tag[i];
                    bq <= tbeats[i];
                end
            end
            assign tag[i+1]    = tq;
            assign tbeats[i+1] = bq;
        end else begin : g_wire
            assign tag[i+1]    = tag[i];
            assign tbeats[i+1] = tbeats[i];
        end
    end

    // Heap layout: node k has children 2k and 2k+1; leaves sit at ELTNUM+lane.
    logic [ELTBIT-1:0] hv [1:NODES-1];
    logic [IDXW-1:0]   hi [1:NODES-1];

    for (genvar l = 0; l < ELTNUM; l++) begin : g_leaf
        assign hv[ELTNUM+l] = inValid ? inVec[l*ELTBIT +: ELTBIT] : '0;
        assign hi[ELTNUM+l] = {cnt[BNW-1:0], LAYER'(l)};
    end

    for (genvar k = 1; k < ELTNUM; k++) begin : g_node
        localparam int LI = LAYER - $clog2(k + 1);
        logic [ELTBIT-1:0] nv;
        logic [IDXW-1:0]   ni;

        ve_cmp_sel #(
            .W     (ELTBIT),
            .IW    (IDXW),
            .SIGNED(SIGNED)
        ) u_node (
            .a_val (hv[2*k]),
            .a_idx (hi[2*k]),
            .b_val (hv[2*k+1]),
            .b_idx (hi[2*k+1]),
            .mode  (tag[LI].mode),
            .val   (nv),
            .idx   (ni),
            .take_b()
        );

        if (PIPE[LI]) begin : g_reg
            logic [ELTBIT-1:0] vq;
            logic [IDXW-1:0]   iq;
            always_ff @(posedge clk) begin
                if (rst) begin
                    vq <= '0;
                    iq <= '0;
                end else if (en) begin
                    vq <= nv;
                    iq <= ni;
                end
            end
            assign hv[k] = vq;
            assign hi[k] = iq;
        end else begin : g_wire
            assign hv[k] = nv;
            assign hi[k] = ni;
        end
    end

    beat_tag_t         at;
    logic [ELTBIT-1:0] acc_val;
    logic [IDXW-1:0]   acc_idx;
    logic [ELTBIT-1:0] mv;
    logic              take;
    logic [ELTBIT-1:0] nxt_val;
    logic [IDXW-1:0]   nxt_idx;

    assign at = tag[LAYER];

    ve_cmp_sel #(
        .W     (ELTBIT),
        .IW    (IDXW),
        .SIGNED(SIGNED)
    ) u_acc (
        .a_val (acc_val),
        .a_idx (acc_idx),
        .b_val (hv[1]),
        .b_idx (hi[1]),
        .mode  (at.mode),
        .val   (mv),
        .idx   (),
        .take_b(take)
    );

    // Winners from beats past MAXBEATS update the value but not the index.
    always_comb begin
        nxt_val = mv;
        nxt_idx = acc_idx;
        if (at.first) begin
            nxt_val = hv[1];
            nxt_idx = hi[1];
        end else if (take && !at.ovf) begin
            nxt_idx = hi[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_val  <= '0;
            acc_idx  <= '0;
            outValid <= 1'b0;
            outElt   <= '0;
            outIdx   <= '0;
            outBeats <= '0;
            outOvf   <= 1'b0;
        end else if (en) begin
            if (at.valid) begin
                acc_val <= nxt_val;
                acc_idx <= nxt_idx;
            end
            outValid <= at.valid & at.last;
            if (at.valid & at.last) begin
                outElt   <= nxt_val;
                outIdx   <= nxt_idx;
                outBeats <= tbeats[LAYER];
                outOvf   <= at.ovf;
            end
        end
    end

endmodule

// File: tb/tb_ve_array_argmax_stream.sv
// Scoreboard bench for ve_array_argmax_stream: directed rows, monitor pops
// expected results whenever a result is handed downstream.
module tb_ve_array_argmax_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid, inReady, inLast, inMode;
    logic [63:0] inVec;
    logic        outValid, outReady, outOvf;
    logic [15:0] outElt;
    logic [3:0]  outIdx;
    logic [2:0]  outBeats;

    logic        u_inValid, u_inReady, u_inLast, u_inMode;
    logic [63:0] u_inVec;
    logic        u_outValid, u_outReady, u_outOvf;
    logic [15:0] u_outElt;
    logic [3:0]  u_outIdx;
    logic [2:0]  u_outBeats;

    always #5 clk = ~clk;

    ve_array_argmax_stream #(
        .ELTNUM(4), .ELTBIT(16), .SIGNED(1), .MAXBEATS(4)
    ) dut (
        .clk(clk), .rst(rst),
        .inValid(inValid), .inReady(inReady), .inLast(inLast),
        .inMode(inMode), .inVec(inVec),
        .outValid(outValid), .outReady(outReady), .outElt(outElt),
        .outIdx(outIdx), .outBeats(outBeats), .outOvf(outOvf)
    );

    ve_array_argmax_stream #(
        .ELTNUM(4), .ELTBIT(16), .SIGNED(0), .MAXBEATS(4)
    ) dut_u (
        .clk(clk), .rst(rst),
        .inValid(u_inValid), .inReady(u_inReady), .inLast(u_inLast),
        .inMode(u_inMode), .inVec(u_inVec),
        .outValid(u_outValid), .outReady(u_outReady), .outElt(u_outElt),
        .outIdx(u_outIdx), .outBeats(u_outBeats), .outOvf(u_outOvf)
    );

    typedef struct {
        logic [15:0] elt;
        logic [3:0]  idx;
        logic [2:0]  beats;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t u_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void check(string nm, longint act, longint req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, req);
        end
    endfunction

    function automatic logic [63:0] lanes(int l0, int l1, int l2, int l3);
        return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
    endfunction

    task automatic push(input logic [15:0] e, input logic [3:0] i,
                        input logic [2:0] b, input logic o);
        exp_t x;
        x.elt = e; x.idx = i; x.beats = b; x.ovf = o;
        exp_q.push_back(x);
    endtask

    task automatic send(input logic [63:0] v, input logic last, input logic mode);
        bit ok;
        int n;
        inValid = 1'b1; inVec = v; inLast = last; inMode = mode;
        ok = 1'b0; n = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = inReady;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: got no accept, want accept");
        end
    endtask

    task automatic idle(input int n);
        inValid = 1'b0; inVec = 'x; inLast = 1'b0; inMode = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && outValid && outReady) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL extra_result: got elt %0h, want none", outElt);
            end else begin
                e = exp_q.pop_front();
                check("elt", outElt, e.elt);
                check("idx", outIdx, e.idx);
                check("beats", outBeats, e.beats);
                check("ovf", outOvf, e.ovf);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && u_outValid && u_outReady) begin
            if (u_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL u_extra_result: got elt %0h, want none", u_outElt);
            end else begin
                e = u_q.pop_front();
                check("u_elt", u_outElt, e.elt);
                check("u_idx", u_outIdx, e.idx);
                check("u_beats", u_outBeats, e.beats);
            end
        end
    end

    initial begin
        exp_t ux;
        int   n;
        rst = 1'b1; outReady = 1'b1;
        u_inValid = 1'b0; u_inVec = '0; u_inLast = 1'b0; u_inMode = 1'b0;
        u_outReady = 1'b1;
        repeat (3) begin
            inValid = 1'($urandom); inVec = {$urandom, $urandom};
            inLast = 1'($urandom); inMode = 1'($urandom);
            outReady = 1'($urandom);
            @(posedge clk);
            #1;
        end
        rst = 1'b0; outReady = 1'b1;
        idle(0);
        @(negedge clk);
        check("rst_valid", outValid, 0);
        check("rst_elt", outElt, 0);
        check("rst_idx", outIdx, 0);
        check("rst_beats", outBeats, 0);
        check("rst_ovf", outOvf, 0);
        check("rst_ready", inReady, 1);
        @(posedge clk);
        #1;

        // single beat MAX with a tie; latency is 2 tree registers + 1
        push(7, 1, 1, 0);
        send(lanes(3, 7, 7, -2), 1, 0);
        idle(0);
        @(negedge clk); check("lat_c1", outValid, 0);
        @(negedge clk); check("lat_c2", outValid, 0);
        @(negedge clk); check("lat_c3", outValid, 1);
        @(posedge clk);
        #1;
        idle(4);

        // two 3-beat MIN rows back to back; later-beat inMode is ignored
        push(1, 10, 3, 0);
        push(2, 5, 3, 0);
        send(lanes(5, 9, 4, 8), 0, 1);
        send(lanes(6, 2, 7, 2), 0, 1);
        send(lanes(3, 2, 1, 9), 1, 1);
        send(lanes(5, 9, 4, 8), 0, 1);
        send(lanes(6, 2, 7, 2), 0, 0);
        send(lanes(3, 2, 2, 9), 1, 0);
        idle(6);

        // signed negatives, MAX then MIN
        push(16'hfffd, 1, 1, 0);
        push(16'hffff, 1, 1, 0);
        send(lanes(-5, -3, -9, -3), 1, 0);
        send(lanes(4, -1, -1, 6), 1, 1);
        idle(6);

        // 0x8000 vs 0x0001 on signed and unsigned instances
        push(1, 1, 1, 0);
        ux.elt = 16'h8000; ux.idx = 0; ux.beats = 1; ux.ovf = 0;
        u_q.push_back(ux);
        u_inValid = 1'b1; u_inVec = lanes(16'h8000, 1, 0, 0);
        u_inLast = 1'b1; u_inMode = 1'b0;
        send(lanes(16'h8000, 1, 0, 0), 1, 0);
        u_inValid = 1'b0; u_inLast = 1'b0;
        idle(6);

        // backpressure with two rows queued
        push(4, 3, 1, 0);
        push(5, 5, 2, 0);
        outReady = 1'b0;
        fork
            begin
                send(lanes(1, 2, 3, 4), 1, 0);
                send(lanes(10, 20, 30, 40), 0, 1);
                send(lanes(50, 5, 60, 5), 1, 0);
                idle(0);
            end
            begin
                n = 0;
                while (!outValid && n < 30) begin
                    @(negedge clk);
                    n++;
                end
                check("bp_seen", outValid, 1);
                repeat (5) begin
                    check("bp_elt", outElt, 4);
                    check("bp_idx", outIdx, 3);
                    check("bp_rdy", inReady, 0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                outReady = 1'b1;
            end
        join
        idle(8);

        // 6-beat row beyond MAXBEATS=4
        push(100, 6, 4, 1);
        send(lanes(1, 2, 3, 4), 0, 0);
        send(lanes(5, 6, 100, 7), 0, 0);
        send(lanes(8, 9, 10, 11), 0, 0);
        send(lanes(8, 9, 10, 11), 0, 0);
        send(lanes(8, 9, 10, 11), 0, 0);
        send(lanes(12, 13, 14, 15), 1, 0);
        idle(8);

        // reset mid-row, then a fresh single-beat row
        send(lanes(500, 600, 700, 800), 0, 0);
        send(lanes(900, 1, 1, 1), 0, 0);
        idle(0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(9, 0, 1, 0);
        send(lanes(9, 8, 7, 6), 1, 0);
        idle(8);

        n = 0;
        while ((exp_q.size() != 0 || u_q.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
        check("u_drain", u_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
